// File: rtl/ext_link_engine.sv
// Serial link engine: auto-baud calibrate/ack framing on the tx/rx pin pair,
// with valid/ready TX and RX queues, ack timeout with bounded retry and RX overrun flag.

module ext_link_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

module ext_link_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int PREFIX_WIDTH  = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int BAUD_SIZE     = 8,
    parameter int TIMEOUT_BAUDS = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 rx,
    output logic                                 tx,
    input  logic [PREFIX_WIDTH+DATA_WIDTH-1:0]   tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    output logic [PREFIX_WIDTH+DATA_WIDTH-1:0]   rx_data,
    output logic                                 rx_valid,
    input  logic                                 rx_ready,
    output logic                                 tx_drop,
    output logic                                 rx_overrun,
    output logic [15:0]                          baud_meas,
    output logic [4:0]                           link_state
);
    localparam int N  = PREFIX_WIDTH + DATA_WIDTH;
    localparam int BW = $clog2(N + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        R_CAL     = 5'd1,
        R_GAP     = 5'd2,
        R_ACK0    = 5'd3,
        R_WSTART  = 5'd4,
        R_HALF    = 5'd5,
        R_BITS    = 5'd6,
        R_GAP2    = 5'd7,
        R_ACK1    = 5'd8,
        T_CAL     = 5'd9,
        T_WACK_L  = 5'd10,
        T_WACK_H  = 5'd11,
        T_GAP     = 5'd12,
        T_START   = 5'd13,
        T_BITS    = 5'd14,
        T_STOP    = 5'd15,
        T_WACK2_L = 5'd16,
        T_WACK2_H = 5'd17
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     bper_q, bper_d;
    logic [15:0]     meas_q, meas_d;
    logic [BW-1:0]   bitn_q, bitn_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            tx_q, tx_d;
    logic            drop_q, drop_d;
    logic            ovr_q, ovr_d;

    logic            tick, tmo_hit, half_hit, wack_fail;
    logic [15:0]     half_m1;
    logic            tx_pop, tx_full, tx_empty;
    logic [N-1:0]    tx_head;
    logic            rx_push, rx_full, rx_empty;

    ext_link_fifo #(.W(N), .DEPTH(FIFO_DEPTH)) u_txq (
        .clk(clk), .rstn(rstn),
        .push(tx_valid), .din(tx_data),
        .pop(tx_pop), .dout(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    ext_link_fifo #(.W(N), .DEPTH(FIFO_DEPTH)) u_rxq (
        .clk(clk), .rstn(rstn),
        .push(rx_push), .din(shreg_q),
        .pop(rx_ready), .dout(rx_data),
        .full(rx_full), .empty(rx_empty)
    );

    assign tx_ready   = !tx_full;
    assign rx_valid   = !rx_empty;
    assign tx         = tx_q;
    assign tx_drop    = drop_q;
    assign rx_overrun = ovr_q;
    assign baud_meas  = meas_q;
    assign link_state = state_q;

    assign tick     = (cnt_q == bper_q - 16'd1);
    assign tmo_hit  = tick && (tmo_q == 16'(TIMEOUT_BAUDS - 1));
    assign half_m1  = (bper_q >> 1) - 16'd1;
    assign half_hit = (cnt_q == half_m1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        tmo_d     = tmo_q;
        len_d     = len_q;
        bper_d    = bper_q;
        meas_d    = meas_q;
        bitn_d    = bitn_q;
        shreg_d   = shreg_q;
        retry_d   = retry_q;
        tx_d      = tx_q;
        drop_d    = 1'b0;
        ovr_d     = ovr_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        wack_fail = 1'b0;
        if (tick) begin
            cnt_d = '0;
            tmo_d = tmo_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = R_CAL;
                    len_d   = 16'd1;
                end else if (!tx_empty) begin
                    state_d = T_CAL;
                    tx_d    = 1'b0;
                    bper_d  = 16'(BAUD_SIZE);
                end
            end
            R_CAL: begin
                if (!rx) begin
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                end else if (len_q < 16'd2) begin
                    state_d = IDLE;
                end else begin
                    meas_d  = len_q;
                    bper_d  = len_q;
                    state_d = R_GAP;
                end
            end
            R_GAP: if (tick) begin
                state_d = R_ACK0;
                tx_d    = 1'b0;
            end
            R_ACK0: if (tick) begin
                state_d = R_WSTART;
                tx_d    = 1'b1;
            end
            R_WSTART: begin
                if (!rx)          state_d = R_HALF;
                else if (tmo_hit) state_d = IDLE;
            end
            // Mid-start check: a high level here means the low was a glitch.
            R_HALF: if (half_hit) begin
                if (rx) begin
                    state_d = R_WSTART;
                end else begin
                    state_d = R_BITS;
                    bitn_d  = '0;
                end
            end
            R_BITS: if (tick) begin
                shreg_d = {shreg_q[N-2:0], rx};
                bitn_d  = bitn_q + BW'(1);
                if (bitn_q == BW'(N - 1)) state_d = R_GAP2;
            end
            // Withholding the ack on a full queue makes the far end retry later.
            R_GAP2: if (tick) begin
                if (rx_full) begin
                    ovr_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    rx_push = 1'b1;
                    tx_d    = 1'b0;
                    state_d = R_ACK1;
                end
            end
            R_ACK1: if (tick) begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
            T_CAL: if (tick) begin
                tx_d    = 1'b1;
                state_d = T_WACK_L;
            end
            T_WACK_L: begin
                if (!rx)          state_d = T_WACK_H;
                else if (tmo_hit) wack_fail = 1'b1;
            end
            T_WACK_H: begin
                if (rx)           state_d = T_GAP;
                else if (tmo_hit) wack_fail = 1'b1;
            end
            T_GAP: if (tick) begin
                tx_d    = 1'b0;
                shreg_d = tx_head;
                state_d = T_START;
            end
            T_START: if (tick) begin
                tx_d    = shreg_q[N-1];
                shreg_d = {shreg_q[N-2:0], 1'b0};
                bitn_d  = '0;
                state_d = T_BITS;
            end
            T_BITS: if (tick) begin
                if (bitn_q == BW'(N - 1)) begin
                    tx_d    = 1'b1;
                    state_d = T_STOP;
                end else begin
                    tx_d    = shreg_q[N-1];
                    shreg_d = {shreg_q[N-2:0], 1'b0};
                    bitn_d  = bitn_q + BW'(1);
                end
            end
            T_STOP: state_d = T_WACK2_L;
            T_WACK2_L: begin
                if (!rx)          state_d = T_WACK2_H;
                else if (tmo_hit) wack_fail = 1'b1;
            end
            T_WACK2_H: begin
                if (rx) begin
                    tx_pop  = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    wack_fail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The head entry stays queued across retries; only the final failure discards it.
        if (wack_fail) begin
            tx_d    = 1'b1;
            state_d = IDLE;
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
            end else begin
                tx_pop  = 1'b1;
                drop_d  = 1'b1;
                retry_d = '0;
            end
        end
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            len_q   <= '0;
            bper_q  <= 16'(BAUD_SIZE);
            meas_q  <= 16'(BAUD_SIZE);
            bitn_q  <= '0;
            retry_q <= '0;
            tx_q    <= 1'b1;
            drop_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            len_q   <= len_d;
            bper_q  <= bper_d;
            meas_q  <= meas_d;
            bitn_q  <= bitn_d;
            retry_q <= retry_d;
            tx_q    <= tx_d;
            drop_q  <= drop_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end
endmodule

// File: tb/tb_ext_link_engine.sv
// Directed bench for ext_link_engine: the bench plays the far end of the link,
// driving rx and sampling tx on the falling clock edge.

module tb_ext_link_engine;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rx;
    logic         tx;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         tx_drop;
    logic         rx_overrun;
    logic [15:0]  baud_meas;
    logic [4:0]   link_state;

    int total = 0;
    int bad = 0;
    int drop_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_drop === 1'b1) drop_cnt++;

    ext_link_engine #(
        .DATA_WIDTH(8), .PREFIX_WIDTH(2), .FIFO_DEPTH(4),
        .BAUD_SIZE(8), .TIMEOUT_BAUDS(16), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rstn(rstn), .rx(rx), .tx(tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_drop(tx_drop), .rx_overrun(rx_overrun),
        .baud_meas(baud_meas), .link_state(link_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (tx !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (tx === lvl);
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (tx === lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Far-end receiver: acks the calibration, captures N bits mid-bit at 8 clk/bit, acks the frame.
    task automatic recv_frame(input string tag, output logic [N-1:0] d, output int cal_len);
        bit ok;
        logic [N-1:0] sh;
        sh = '0;
        wait_tx(1'b0, 300, ok);
        chk({tag, "_cal_seen"}, ok, 1);
        count_level(1'b0, cal_len);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        wait_tx(1'b0, 100, ok);
        chk({tag, "_start_seen"}, ok, 1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            repeat (8) @(negedge clk);
            sh = {sh[N-2:0], tx};
        end
        d = sh;
        repeat (8) @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
    endtask

    // Far-end sender at L clk/bit; ack1 is 0 when the frame ack never arrives.
    task automatic send_frame(input logic [N-1:0] d, input int L, input bit push_en,
                              input logic [N-1:0] push_word, output int ack0, output int ack1);
        bit ok;
        rx = 1'b0;
        if (push_en) begin
            tx_data  = push_word;
            tx_valid = 1'b1;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (L - 1) @(negedge clk);
        rx = 1'b1;
        wait_tx(1'b0, 3 * L + 10, ok);
        chk("ack0_seen", ok, 1);
        count_level(1'b0, ack0);
        rx = 1'b0;
        repeat (L) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rx = d[N-1-i];
            repeat (L) @(negedge clk);
        end
        rx = 1'b1;
        wait_tx(1'b0, 3 * L, ok);
        if (ok) count_level(1'b0, ack1);
        else ack1 = 0;
    endtask

    initial begin
        logic [N-1:0] got;
        logic [N-1:0] fr [0:3];
        int n, a0, a1, c, d0;

        fr[0] = 10'h001; fr[1] = 10'h3FE; fr[2] = 10'h155; fr[3] = 10'h2AA;
        rstn = 1'b0; rx = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_drop", tx_drop, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_baud", baud_meas, 8);
        chk("rst_state", link_state, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: transmit 10'h2A5 to an acking far end
        tx_data = 10'h2A5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t1_tx_ready", tx_ready, 1);
        recv_frame("t1", got, n);
        chk("t1_cal_len", n, 8);
        chk("t1_data", got, 10'h2A5);
        repeat (20) @(negedge clk);
        chk("t1_idle_state", link_state, 0);
        chk("t1_idle_tx", tx, 1);
        chk("t1_tx_ready", tx_ready, 1);
        chk("t1_no_drop", drop_cnt, 0);

        // 2: receive 10'h0C3 at 12 clk/bit
        send_frame(10'h0C3, 12, 1'b0, '0, a0, a1);
        chk("t2_baud_meas", baud_meas, 12);
        chk("t2_ack0_len", a0, 12);
        chk("t2_ack1_len", a1, 12);
        chk("t2_rx_valid", rx_valid, 1);
        chk("t2_rx_data", rx_data, 10'h0C3);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t2_popped", rx_valid, 0);

        // 3: far end never acks
        d0 = drop_cnt;
        tx_data = 10'h3FF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bit ok;
            wait_tx(1'b0, 300, ok);
            chk("t3_attempt_seen", ok, 1);
            count_level(1'b0, n);
            chk("t3_cal_len", n, 8);
            if (a < 3) begin
                count_level(1'b1, n);
                chk("t3_retry_gap", n, 129);
            end else begin
                c = 0;
                while (tx_drop !== 1'b1 && c < 300) begin
                    @(negedge clk);
                    c++;
                end
                chk("t3_drop_delay", c, 128);
                @(negedge clk);
                chk("t3_drop_pulse_end", tx_drop, 0);
            end
        end
        repeat (30) @(negedge clk);
        chk("t3_drop_count", drop_cnt - d0, 1);
        chk("t3_idle_state", link_state, 0);
        chk("t3_idle_tx", tx, 1);

        // 4: fill the RX queue, then overrun
        for (int i = 0; i < 4; i++) begin
            send_frame(fr[i], 9, 1'b0, '0, a0, a1);
            chk("t4_ack1_len", a1, 9);
        end
        chk("t4_baud_meas", baud_meas, 9);
        chk("t4_no_overrun_yet", rx_overrun, 0);
        chk("t4_full_valid", rx_valid, 1);
        send_frame(10'h0F0, 9, 1'b0, '0, a0, a1);
        chk("t4_no_final_ack", a1, 0);
        chk("t4_overrun", rx_overrun, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_order_valid", rx_valid, 1);
            chk("t4_order_data", rx_data, fr[i]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        chk("t4_drained", rx_valid, 0);

        // 5: one-clock glitch, then rx and tx arriving together
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_glitch_state", link_state, 0);
        chk("t5_glitch_tx", tx, 1);
        chk("t5_glitch_baud", baud_meas, 9);
        send_frame(10'h2C7, 10, 1'b1, 10'h1B4, a0, a1);
        chk("t5_rx_first_ack0", a0, 10);
        chk("t5_rx_first_ack1", a1, 10);
        chk("t5_rx_data", rx_data, 10'h2C7);
        recv_frame("t5", got, n);
        chk("t5_tx_cal_len", n, 8);
        chk("t5_tx_data", got, 10'h1B4);
        repeat (5) @(negedge clk);
        chk("t5_idle_state", link_state, 0);

        // 6: reset during T_BITS (RX queue still holds the 10'h2C7 frame)
        tx_data = 10'h155; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        begin
            bit ok;
            wait_tx(1'b0, 300, ok);
            chk("t6_cal_seen", ok, 1);
            count_level(1'b0, n);
            rx = 1'b0;
            repeat (8) @(negedge clk);
            rx = 1'b1;
            wait_tx(1'b0, 100, ok);
            chk("t6_start_seen", ok, 1);
        end
        repeat (28) @(negedge clk);
        chk("t6_pre_state", link_state, 14);
        chk("t6_pre_tx", tx, 0);
        chk("t6_pre_rx_valid", rx_valid, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_tx", tx, 1);
        chk("t6_tx_ready", tx_ready, 1);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_state", link_state, 0);
        chk("t6_overrun_clr", rx_overrun, 0);
        chk("t6_baud", baud_meas, 8);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_post_state", link_state, 0);
        chk("t6_post_tx", tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
